// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline.
// Drives register enables/bubbles, counts stall cycles, watches MUL/DIV.
module pipeline_hazard_ctrl #(
    parameter int MDU_MAX_CYCLES = 40,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 IMEM_BUSYWAIT,
    input  logic                 DMEM_BUSYWAIT,
    input  logic                 MEM_READ_EN_IDEX,
    input  logic [4:0]           REG_WRITE_ADDR_IDEX,
    input  logic [4:0]           RS1_ADDR_IFID,
    input  logic [4:0]           RS2_ADDR_IFID,
    input  logic                 RS1_USED_ID,
    input  logic                 RS2_USED_ID,
    input  logic                 BRANCH_TAKEN_EX,
    input  logic                 MDU_START_EX,
    input  logic                 MDU_DONE,
    output logic                 PC_EN,
    output logic                 IFID_EN,
    output logic                 IDEX_EN,
    output logic                 EXMEM_EN,
    output logic                 MEMWB_EN,
    output logic                 IFID_FLUSH,
    output logic                 IDEX_FLUSH,
    output logic                 EXMEM_FLUSH,
    output logic [CNT_WIDTH-1:0] STALL_COUNT,
    output logic                 MDU_TIMEOUT
);

    localparam int WD_W = $clog2(MDU_MAX_CYCLES + 1);

    typedef enum logic {
        RUN,
        MDU_WAIT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WD_W-1:0] wd;
    logic [WD_W-1:0] wd_nxt;
    logic            timeout_set;
    logic            load_use;
    logic            wd_last;

    assign load_use = MEM_READ_EN_IDEX && (REG_WRITE_ADDR_IDEX != 5'd0) &&
                      ((RS1_USED_ID && (RS1_ADDR_IFID == REG_WRITE_ADDR_IDEX)) ||
                       (RS2_USED_ID && (RS2_ADDR_IFID == REG_WRITE_ADDR_IDEX)));

    assign wd_last = (wd == WD_W'(MDU_MAX_CYCLES - 1));

    always_comb begin
        PC_EN       = 1'b0;
        IFID_EN     = 1'b0;
        IDEX_EN     = 1'b0;
        EXMEM_EN    = 1'b0;
        MEMWB_EN    = 1'b0;
        IFID_FLUSH  = 1'b0;
        IDEX_FLUSH  = 1'b0;
        EXMEM_FLUSH = 1'b0;
        state_nxt   = state;
        wd_nxt      = wd;
        timeout_set = 1'b0;
        if (!RESET) begin
            state_nxt = RUN;
        end else if (DMEM_BUSYWAIT) begin
            // whole pipe frozen; FSM and watchdog hold
        end else if (state == MDU_WAIT && !MDU_DONE) begin
            if (wd_last) begin
                {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN} = 5'b11111;
                timeout_set = 1'b1;
                state_nxt   = RUN;
                wd_nxt      = '0;
            end else begin
                EXMEM_EN    = 1'b1;
                EXMEM_FLUSH = 1'b1;
                MEMWB_EN    = 1'b1;
                wd_nxt      = wd + WD_W'(1);
            end
        end else if (state == MDU_WAIT) begin
            {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN} = 5'b11111;
            state_nxt = RUN;
            wd_nxt    = '0;
        end else if (BRANCH_TAKEN_EX) begin
            {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN} = 5'b11111;
            IFID_FLUSH = 1'b1;
            IDEX_FLUSH = 1'b1;
        end else if (MDU_START_EX) begin
            EXMEM_EN    = 1'b1;
            EXMEM_FLUSH = 1'b1;
            MEMWB_EN    = 1'b1;
            state_nxt   = MDU_WAIT;
            wd_nxt      = WD_W'(1);
        end else if (load_use) begin
            IDEX_EN    = 1'b1;
            IDEX_FLUSH = 1'b1;
            EXMEM_EN   = 1'b1;
            MEMWB_EN   = 1'b1;
        end else if (IMEM_BUSYWAIT) begin
            {IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN} = 4'b1111;
            IFID_FLUSH = 1'b1;
        end else begin
            {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN} = 5'b11111;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state       <= RUN;
            wd          <= '0;
            STALL_COUNT <= '0;
            MDU_TIMEOUT <= 1'b0;
        end else begin
            state <= state_nxt;
            wd    <= wd_nxt;
            if (timeout_set) begin
                MDU_TIMEOUT <= 1'b1;
            end
            if (!PC_EN && (STALL_COUNT != '1)) begin
                STALL_COUNT <= STALL_COUNT + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic checked against a rule-level model.
module tb_pipeline_hazard_ctrl;

    localparam int MAXC = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLK;
    logic          RESET;
    logic          IMEM_BUSYWAIT;
    logic          DMEM_BUSYWAIT;
    logic          MEM_READ_EN_IDEX;
    logic [4:0]    REG_WRITE_ADDR_IDEX;
    logic [4:0]    RS1_ADDR_IFID;
    logic [4:0]    RS2_ADDR_IFID;
    logic          RS1_USED_ID;
    logic          RS2_USED_ID;
    logic          BRANCH_TAKEN_EX;
    logic          MDU_START_EX;
    logic          MDU_DONE;
    logic          PC_EN;
    logic          IFID_EN;
    logic          IDEX_EN;
    logic          EXMEM_EN;
    logic          MEMWB_EN;
    logic          IFID_FLUSH;
    logic          IDEX_FLUSH;
    logic          EXMEM_FLUSH;
    logic [CW-1:0] STALL_COUNT;
    logic          MDU_TIMEOUT;

    pipeline_hazard_ctrl #(
        .MDU_MAX_CYCLES(MAXC),
        .CNT_WIDTH     (CW)
    ) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .IMEM_BUSYWAIT      (IMEM_BUSYWAIT),
        .DMEM_BUSYWAIT      (DMEM_BUSYWAIT),
        .MEM_READ_EN_IDEX   (MEM_READ_EN_IDEX),
        .REG_WRITE_ADDR_IDEX(REG_WRITE_ADDR_IDEX),
        .RS1_ADDR_IFID      (RS1_ADDR_IFID),
        .RS2_ADDR_IFID      (RS2_ADDR_IFID),
        .RS1_USED_ID        (RS1_USED_ID),
        .RS2_USED_ID        (RS2_USED_ID),
        .BRANCH_TAKEN_EX    (BRANCH_TAKEN_EX),
        .MDU_START_EX       (MDU_START_EX),
        .MDU_DONE           (MDU_DONE),
        .PC_EN              (PC_EN),
        .IFID_EN            (IFID_EN),
        .IDEX_EN            (IDEX_EN),
        .EXMEM_EN           (EXMEM_EN),
        .MEMWB_EN           (MEMWB_EN),
        .IFID_FLUSH         (IFID_FLUSH),
        .IDEX_FLUSH         (IDEX_FLUSH),
        .EXMEM_FLUSH        (EXMEM_FLUSH),
        .STALL_COUNT        (STALL_COUNT),
        .MDU_TIMEOUT        (MDU_TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {PC,IFID,IDEX,EXMEM,MEMWB, IFID_FL,IDEX_FL,EXMEM_FL}
    localparam logic [7:0] C_ZERO = 8'b00000_000;
    localparam logic [7:0] C_RUN  = 8'b11111_000;
    localparam logic [7:0] C_MDU  = 8'b00011_001;
    localparam logic [7:0] C_LU   = 8'b00111_010;
    localparam logic [7:0] C_IMEM = 8'b01111_100;
    localparam logic [7:0] C_BR   = 8'b11111_110;

    int n_vec;
    int n_err;

    // reference model state
    bit m_mdu;
    int m_wait;
    bit m_to;
    int m_cnt;

    logic [7:0]    exp_ctl;
    logic [7:0]    act_ctl;
    logic [CW-1:0] act_cnt;
    logic          act_to;

    function automatic bit hazard();
        bit h1, h2;
        h1 = RS1_USED_ID && RS1_ADDR_IFID == REG_WRITE_ADDR_IDEX;
        h2 = RS2_USED_ID && RS2_ADDR_IFID == REG_WRITE_ADDR_IDEX;
        return MEM_READ_EN_IDEX && REG_WRITE_ADDR_IDEX != 0 && (h1 || h2);
    endfunction

    function automatic logic [7:0] model_ctl();
        if (!RESET || DMEM_BUSYWAIT) return C_ZERO;
        if (m_mdu && !MDU_DONE) return (m_wait == MAXC - 1) ? C_RUN : C_MDU;
        if (m_mdu) return C_RUN;
        if (BRANCH_TAKEN_EX) return C_BR;
        if (MDU_START_EX) return C_MDU;
        if (hazard()) return C_LU;
        if (IMEM_BUSYWAIT) return C_IMEM;
        return C_RUN;
    endfunction

    task automatic model_edge(input logic [7:0] ctl);
        if (!RESET) begin
            m_mdu = 0; m_wait = 0; m_to = 0; m_cnt = 0;
        end else begin
            if (!ctl[7] && m_cnt < CMAX) m_cnt++;
            if (DMEM_BUSYWAIT) begin
            end else if (m_mdu && !MDU_DONE) begin
                if (m_wait == MAXC - 1) begin
                    m_to = 1; m_mdu = 0; m_wait = 0;
                end else begin
                    m_wait++;
                end
            end else if (m_mdu) begin
                m_mdu = 0; m_wait = 0;
            end else if (!BRANCH_TAKEN_EX && MDU_START_EX) begin
                m_mdu = 1; m_wait = 1;
            end
        end
    endtask

    // one clock: called at negedge with inputs already set
    task automatic step();
        #1;
        exp_ctl = model_ctl();
        act_ctl = {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN,
                   IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH};
        @(posedge CLK);
        model_edge(exp_ctl);
        #1;
        act_cnt = STALL_COUNT;
        act_to  = MDU_TIMEOUT;
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        IMEM_BUSYWAIT = 0; DMEM_BUSYWAIT = 0; MEM_READ_EN_IDEX = 0;
        REG_WRITE_ADDR_IDEX = 0; RS1_ADDR_IFID = 0; RS2_ADDR_IFID = 0;
        RS1_USED_ID = 0; RS2_USED_ID = 0; BRANCH_TAKEN_EX = 0;
        MDU_START_EX = 0; MDU_DONE = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 0;
        step();
        RESET = 1;
    endtask

    task automatic test_reset();
        RESET = 0;
        for (int i = 0; i < 2; i++) begin
            {IMEM_BUSYWAIT, DMEM_BUSYWAIT, MEM_READ_EN_IDEX, RS1_USED_ID,
             RS2_USED_ID, BRANCH_TAKEN_EX, MDU_START_EX, MDU_DONE} = 8'($urandom);
            REG_WRITE_ADDR_IDEX = 5'($urandom);
            RS1_ADDR_IFID = 5'($urandom);
            RS2_ADDR_IFID = 5'($urandom);
            step();
            n_vec++;
            if (act_ctl !== C_ZERO) begin
                n_err++;
                $display("FAIL reset_ctl: got %b want %b", act_ctl, C_ZERO);
            end
        end
        n_vec++;
        if (act_cnt !== 0 || act_to !== 0) begin
            n_err++;
            $display("FAIL reset_state: cnt %0d to %b want 0 0", act_cnt, act_to);
        end
        RESET = 1;
        idle_inputs();
    endtask

    task automatic test_load_use();
        MEM_READ_EN_IDEX = 1; REG_WRITE_ADDR_IDEX = 5;
        RS1_ADDR_IFID = 3; RS1_USED_ID = 1;
        RS2_ADDR_IFID = 5; RS2_USED_ID = 1;
        step();
        n_vec++;
        if (act_ctl !== C_LU) begin
            n_err++;
            $display("FAIL load_use: got %b want %b", act_ctl, C_LU);
        end
        // bubble now in EX: the hazard is gone
        MEM_READ_EN_IDEX = 0; REG_WRITE_ADDR_IDEX = 0;
        step();
        n_vec++;
        if (act_ctl !== C_RUN) begin
            n_err++;
            $display("FAIL load_use_once: got %b want %b", act_ctl, C_RUN);
        end
        MEM_READ_EN_IDEX = 1; REG_WRITE_ADDR_IDEX = 0;
        RS1_ADDR_IFID = 0; RS2_ADDR_IFID = 0;
        step();
        n_vec++;
        if (act_ctl !== C_RUN) begin
            n_err++;
            $display("FAIL load_use_x0: got %b want %b", act_ctl, C_RUN);
        end
        idle_inputs();
    endtask

    task automatic test_mul();
        do_reset();
        MDU_START_EX = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (act_ctl !== C_MDU) begin
                n_err++;
                $display("FAIL mul_wait%0d: got %b want %b", i, act_ctl, C_MDU);
            end
        end
        MDU_DONE = 1;
        step();
        n_vec++;
        if (act_ctl !== C_RUN) begin
            n_err++;
            $display("FAIL mul_done: got %b want %b", act_ctl, C_RUN);
        end
        n_vec++;
        if (act_cnt !== 4) begin
            n_err++;
            $display("FAIL mul_count: got %0d want 4", act_cnt);
        end
        idle_inputs();
        step();
        n_vec++;
        if (act_ctl !== C_RUN) begin
            n_err++;
            $display("FAIL mul_after: got %b want %b", act_ctl, C_RUN);
        end
    endtask

    task automatic test_dmem_in_mdu();
        do_reset();
        MDU_START_EX = 1;
        step();
        MDU_START_EX = 0;
        step();
        DMEM_BUSYWAIT = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (act_ctl !== C_ZERO) begin
                n_err++;
                $display("FAIL dmem_freeze%0d: got %b want %b", i, act_ctl, C_ZERO);
            end
        end
        DMEM_BUSYWAIT = 0;
        // watchdog held at 2: five more stall cycles, then it fires
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (act_ctl !== C_MDU) begin
                n_err++;
                $display("FAIL dmem_resume%0d: got %b want %b", i, act_ctl, C_MDU);
            end
        end
        n_vec++;
        if (act_to !== 0) begin
            n_err++;
            $display("FAIL dmem_early_to: got %b want 0", act_to);
        end
        step();
        n_vec++;
        if (act_ctl !== C_RUN || act_to !== 1 || act_cnt !== 10) begin
            n_err++;
            $display("FAIL dmem_fire: ctl %b to %b cnt %0d want %b 1 10",
                     act_ctl, act_to, act_cnt, C_RUN);
        end
    endtask

    task automatic test_branch();
        do_reset();
        BRANCH_TAKEN_EX = 1; IMEM_BUSYWAIT = 1;
        MEM_READ_EN_IDEX = 1; REG_WRITE_ADDR_IDEX = 7;
        RS1_ADDR_IFID = 7; RS1_USED_ID = 1;
        step();
        n_vec++;
        if (act_ctl !== C_BR) begin
            n_err++;
            $display("FAIL branch_prio: got %b want %b", act_ctl, C_BR);
        end
        BRANCH_TAKEN_EX = 0; MEM_READ_EN_IDEX = 0;
        step();
        n_vec++;
        if (act_ctl !== C_IMEM) begin
            n_err++;
            $display("FAIL imem_busy: got %b want %b", act_ctl, C_IMEM);
        end
        idle_inputs();
    endtask

    task automatic test_watchdog();
        do_reset();
        MDU_START_EX = 1;
        step();
        MDU_START_EX = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_vec++;
            if (act_ctl !== C_MDU || act_to !== 0) begin
                n_err++;
                $display("FAIL wd_wait%0d: ctl %b to %b want %b 0", i, act_ctl, act_to, C_MDU);
            end
        end
        step();
        n_vec++;
        if (act_ctl !== C_RUN || act_to !== 1) begin
            n_err++;
            $display("FAIL wd_fire: ctl %b to %b want %b 1", act_ctl, act_to, C_RUN);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (act_ctl !== C_RUN || act_to !== 1) begin
                n_err++;
                $display("FAIL wd_sticky%0d: ctl %b to %b want %b 1", i, act_ctl, act_to, C_RUN);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        IMEM_BUSYWAIT = 1;
        for (int i = 0; i < CMAX + 3; i++) step();
        n_vec++;
        if (act_cnt !== CW'(CMAX)) begin
            n_err++;
            $display("FAIL cnt_sat: got %0d want %0d", act_cnt, CMAX);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            RESET = ($urandom_range(0, 59) != 0);
            DMEM_BUSYWAIT = ($urandom_range(0, 5) == 0);
            IMEM_BUSYWAIT = ($urandom_range(0, 4) == 0);
            BRANCH_TAKEN_EX = ($urandom_range(0, 5) == 0);
            MDU_START_EX = ($urandom_range(0, 7) == 0);
            MDU_DONE = ($urandom_range(0, 5) == 0);
            MEM_READ_EN_IDEX = $urandom_range(0, 1);
            REG_WRITE_ADDR_IDEX = 5'($urandom_range(0, 3));
            RS1_ADDR_IFID = 5'($urandom_range(0, 3));
            RS2_ADDR_IFID = 5'($urandom_range(0, 3));
            RS1_USED_ID = $urandom_range(0, 1);
            RS2_USED_ID = $urandom_range(0, 1);
            step();
            n_vec++;
            if (act_ctl !== exp_ctl) begin
                n_err++;
                $display("FAIL rnd_ctl@%0d: got %b want %b", i, act_ctl, exp_ctl);
            end
            n_vec++;
            if (act_cnt !== CW'(m_cnt) || act_to !== m_to) begin
                n_err++;
                $display("FAIL rnd_state@%0d: cnt %0d to %b want %0d %b",
                         i, act_cnt, act_to, m_cnt, m_to);
            end
        end
        idle_inputs();
        RESET = 1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_mdu = 0; m_wait = 0; m_to = 0; m_cnt = 0;
        RESET = 0;
        idle_inputs();
        @(negedge CLK);
        test_reset();
        test_load_use();
        test_mul();
        test_dmem_in_mdu();
        test_branch();
        test_watchdog();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
